// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO and its read-side consumer.
//   FIFO_DATA_WIDTH : default word width, common to the FIFO and the reader
//   rs_state_t      : read-stream control states (IDLE, RUN, STOP)
//   ptr_width()     : pointer width needed to index a buffer of a given depth
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } rs_state_t;

   // Width of a circular-buffer pointer; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      if (depth <= 2) begin
         return 1;
      end else begin
         return $clog2(depth);
      end
   endfunction

endpackage : fifo_pkg

// File: rtl/rs_skid_buf.sv
// -----------------------------------------------------------------------------
// rs_skid_buf
// Small circular buffer that absorbs words already requested from the FIFO
// while the stream consumer is stalled.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (pointers and occupancy)
//   push_i  : write din_i at the tail (caller guarantees room)
//   pop_i   : drop the head entry (caller guarantees non-empty)
//   din_i   : word to write
//   occ_o   : number of valid entries, 0..BUF_DEPTH
//   head_o  : oldest entry (meaningful only while occ_o != 0)
// -----------------------------------------------------------------------------
module rs_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            push_i,
   input  logic                            pop_i,
   input  logic [DATA_WIDTH-1:0]           din_i,
   output logic [ptr_width(BUF_DEPTH):0]   occ_o,
   output logic [DATA_WIDTH-1:0]           head_o
);

   localparam int PW = ptr_width(BUF_DEPTH);
   localparam int OW = PW + 1;

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q;
   logic [PW-1:0]         rd_ptr_d;
   logic [OW-1:0]         occ_q;
   logic [OW-1:0]         occ_d;

   // Next pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         occ_q    <= {OW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage array; contents are qualified by occupancy, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign occ_o  = occ_q;
   assign head_o = mem_q[rd_ptr_q];

endmodule : rs_skid_buf

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side consumer of the asynchronous FIFO (rd_clk domain only). Issues
// reads against a FIFO with one-cycle read latency and re-presents the words
// as a valid/ready stream framed into packets of PKT_LEN words. Reads are
// issued only when the skid buffer has a credit for the returning word, so
// back-pressure never loses data and m_ready_i never reaches fifo_rd_en_o.
//   rd_clk_i     : clock
//   rst_ni       : asynchronous active-low reset
//   enable_i     : level; fetch packets while high, finish the packet when low
//   fifo_empty_i : FIFO empty flag
//   fifo_rd_en_o : FIFO read request
//   fifo_valid_i : FIFO read data valid (one cycle after an accepted read)
//   fifo_dout_i  : FIFO read data
//   m_valid_o    : stream word valid
//   m_ready_i    : stream consumer ready
//   m_data_o     : stream word (zero while m_valid_o is low)
//   m_last_o     : last word of a packet
//   busy_o       : not idle, buffer non-empty, or a read in flight
//   pkt_done_o   : one-cycle pulse after the handshake of a last word
//   err_o        : sticky; unexpected fifo_valid_i or buffer overflow attempt
// -----------------------------------------------------------------------------
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int BUF_DEPTH  = 4,
   parameter int PKT_LEN    = 16
) (
   input  logic                  rd_clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rd_en_o,
   input  logic                  fifo_valid_i,
   input  logic [DATA_WIDTH-1:0] fifo_dout_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  m_last_o,
   output logic                  busy_o,
   output logic                  pkt_done_o,
   output logic                  err_o
);

   localparam int PW = ptr_width(BUF_DEPTH);
   localparam int OW = PW + 1;
   localparam int CW = $clog2(PKT_LEN);

   localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
   localparam logic [OW-1:0] DEPTH_C  = OW'(BUF_DEPTH);

   rs_state_t             state_q;
   rs_state_t             state_d;
   logic [CW-1:0]         issue_cnt_q;
   logic [CW-1:0]         issue_cnt_d;
   logic [CW-1:0]         out_cnt_q;
   logic [CW-1:0]         out_cnt_d;
   logic                  inflight_q;
   logic                  err_q;
   logic                  err_d;
   logic                  pkt_done_q;
   logic                  pkt_done_d;

   logic [OW-1:0]         occ_s;
   logic [DATA_WIDTH-1:0] head_s;
   logic [OW-1:0]         credit_s;
   logic                  stop_done_s;
   logic                  rd_en_s;
   logic                  m_valid_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  full_s;
   logic                  last_s;

   rs_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_skid (
      .clk_i  (rd_clk_i),
      .rst_ni (rst_ni),
      .push_i (push_s),
      .pop_i  (pop_s),
      .din_i  (fifo_dout_i),
      .occ_o  (occ_s),
      .head_o (head_s)
   );

   // Credits: buffered words plus the word still on its way from the FIFO.
   assign credit_s = occ_s + OW'(inflight_q);

   // In STOP the packet is complete once the issue counter has wrapped back
   // to zero; entering STOP on a packet boundary completes immediately.
   assign stop_done_s = (state_q == STOP) && (issue_cnt_q == {CW{1'b0}});

   assign rd_en_s = (state_q != IDLE) && !fifo_empty_i &&
                    (credit_s < DEPTH_C) && !stop_done_s;

   assign m_valid_s = (occ_s != {OW{1'b0}});
   assign pop_s     = m_valid_s && m_ready_i;
   assign full_s    = (occ_s == DEPTH_C);
   // A word arriving into a full buffer is kept only if the head leaves now.
   assign push_s    = fifo_valid_i && (!full_s || pop_s);
   assign last_s    = m_valid_s && (out_cnt_q == CNT_LAST);

   // Control FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable_i && !fifo_empty_i) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (!enable_i) begin
               state_d = STOP;
            end else begin
               state_d = RUN;
            end
         end
         STOP: begin
            if (stop_done_s) begin
               state_d = IDLE;
            end else if (enable_i) begin
               state_d = RUN;
            end else begin
               state_d = STOP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Issue/output word counters, completion pulse and sticky error.
   always_comb begin
      issue_cnt_d = issue_cnt_q;
      out_cnt_d   = out_cnt_q;
      pkt_done_d  = 1'b0;
      err_d       = err_q;

      if (rd_en_s) begin
         if (issue_cnt_q == CNT_LAST) begin
            issue_cnt_d = {CW{1'b0}};
         end else begin
            issue_cnt_d = issue_cnt_q + CW'(1);
         end
      end else begin
         issue_cnt_d = issue_cnt_q;
      end

      if (pop_s) begin
         if (out_cnt_q == CNT_LAST) begin
            out_cnt_d = {CW{1'b0}};
         end else begin
            out_cnt_d = out_cnt_q + CW'(1);
         end
      end else begin
         out_cnt_d = out_cnt_q;
      end

      pkt_done_d = pop_s && last_s;

      // Data nobody asked for, or data with nowhere to go.
      if (fifo_valid_i && (!inflight_q || (full_s && !pop_s))) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge rd_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         issue_cnt_q <= {CW{1'b0}};
         out_cnt_q   <= {CW{1'b0}};
         inflight_q  <= 1'b0;
         pkt_done_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         out_cnt_q   <= out_cnt_d;
         inflight_q  <= rd_en_s;
         pkt_done_q  <= pkt_done_d;
         err_q       <= err_d;
      end
   end

   assign fifo_rd_en_o = rd_en_s;
   assign m_valid_o    = m_valid_s;
   // Zero the data lane when no word is presented so reset shows all-zero.
   assign m_data_o     = m_valid_s ? head_s : {DATA_WIDTH{1'b0}};
   assign m_last_o     = last_s;
   assign busy_o       = (state_q != IDLE) || m_valid_s || inflight_q;
   assign pkt_done_o   = pkt_done_q;
   assign err_o        = err_q;

endmodule : fifo_rd_stream
